sp1_ram_arb: RTL and testbench

- Two-requester front end that sits directly upstream of sp1_ram and owns its cs/we/adrs/din pins.
- Arbitrates per cycle between requester 0 (evaluator core) and requester 1 (GC/loader).
- Routes each registered read result back to the requester that issued it, with a valid strobe and a holding register.

---
 rtl/sp1_ram_arb_pkg.sv | 36 +++
 rtl/sp1_rr_arb2.sv | 34 +++
 rtl/sp1_ram_arb.sv | 101 ++++++++++
 tb/tb_sp1_ram_arb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sp1_ram_arb_pkg.sv
// Shared constants and grant helpers for the sp1_ram two-port arbiter.
// Default AW/DW and port indices live here so every file agrees on them.
package sp1_ram_arb_pkg;

  localparam int SP1_AW = 8;
  localparam int SP1_DW = 32;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  typedef logic [1:0] req_vec_t;

  // Round-robin pick: on contention the port that did not win last time goes.
  // Any non-1 request bit (including X in simulation) falls into default = no grant.
  function automatic req_vec_t rr_pick(input req_vec_t req, input logic lgnt);
    req_vec_t g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (lgnt == ARB_P1) ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  function automatic req_vec_t fixed_pick(input req_vec_t req);
    req_vec_t g;
    case (req)
      2'b01, 2'b11: g = 2'b01;
      2'b10:        g = 2'b10;
      default:      g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sp1_rr_arb2.sv
// Two-way grant logic. Round robin with an lgnt register when SP1_RAM_ARB_RR_EN
// is defined, otherwise fixed priority with port 0 winning.
module sp1_rr_arb2
  import sp1_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef SP1_RAM_ARB_RR_EN
  logic lgnt_reg;

  assign gnt = rr_pick(req, lgnt_reg);

  // lgnt only moves on granted cycles; idle cycles keep the last winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lgnt_reg <= ARB_P1;
    end else if (gnt[0]) begin
      lgnt_reg <= ARB_P0;
    end else if (gnt[1]) begin
      lgnt_reg <= ARB_P1;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = &{1'b0, clk, rst};
  assign gnt = fixed_pick(req);
`endif

endmodule

// File: rtl/sp1_ram_arb.sv
// Two-requester front end for sp1_ram: grant, pin mux, read-return routing and hold
// registers. Arbitration mode selected by SP1_RAM_ARB_RR_EN (see sp1_rr_arb2).
module sp1_ram_arb
  import sp1_ram_arb_pkg::*;
#(
  parameter int AW = SP1_AW,
  parameter int DW = SP1_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] adrs0,
  input  logic [AW-1:0] adrs1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_adrs,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [1:0]    gnt;
  logic [1:0]    we_v;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata_v [2];
  logic          rd_pend_reg;
  logic          rd_port_reg;

  assign we_v = {we1, we0};

  sp1_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1, req0}),
    .gnt (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Pins are forced to zero when nobody is granted so the RAM never sees X.
  always_comb begin
    ram_cs   = |gnt;
    ram_we   = 1'b0;
    ram_adrs = '0;
    ram_din  = '0;
    if (gnt[0]) begin
      ram_we   = we0;
      ram_adrs = adrs0;
      ram_din  = din0;
    end else if (gnt[1]) begin
      ram_we   = we1;
      ram_adrs = adrs1;
      ram_din  = din1;
    end
  end

  // Captured at the same edge sp1_ram registers dout, so rvalid lines up with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_reg <= 1'b0;
      rd_port_reg <= ARB_P0;
    end else begin
      rd_pend_reg <= |(gnt & ~we_v);
      rd_port_reg <= gnt[1] ? ARB_P1 : ARB_P0;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DW-1:0] hold_reg;

      assign rvalid[gi]  = rd_pend_reg && (rd_port_reg == 1'(gi));
      assign rdata_v[gi] = rvalid[gi] ? ram_dout : hold_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_reg <= '0;
        end else if (rvalid[gi]) begin
          hold_reg <= ram_dout;
        end
      end
    end
  endgenerate

  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata_v[0];
  assign rdata1  = rdata_v[1];

endmodule

// File: tb/tb_sp1_ram_arb.sv
// Self-checking bench for sp1_ram_arb with a behavioural sp1_ram and a read scoreboard.
// Contention expectations follow SP1_RAM_ARB_RR_EN.
module tb_sp1_ram_arb;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] adrs0, adrs1;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_adrs;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ref_mem [256];

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp1_ram_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adrs0(adrs0), .adrs1(adrs1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_adrs(ram_adrs), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Behavioural sp1_ram: write at the edge, registered read data.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_adrs] <= ram_din;
      else        ram_dout <= ram_mem[ram_adrs];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h t=%0t", tag, got, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; adrs0 = a0; din0 = d0;
    req1 = r1; we1 = w1; adrs1 = a1; din1 = d1;
  endtask

  // One bus cycle: check grants/pins mid-cycle, update reference memory or
  // push the expected read result, then advance to just after the next edge.
  task automatic step(input logic eg0, input logic eg1);
    @(negedge clk);
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("ram_cs", ram_cs, eg0 | eg1);
    if (eg0) begin
      chk("ram_adrs0", ram_adrs, adrs0);
      chk("ram_we0", ram_we, we0);
      if (we0) ref_mem[adrs0] = din0;
      else sb.push_back('{1'b0, ref_mem[adrs0]});
    end else if (eg1) begin
      chk("ram_adrs1", ram_adrs, adrs1);
      chk("ram_we1", ram_we, we1);
      if (we1) ref_mem[adrs1] = din1;
      else sb.push_back('{1'b1, ref_mem[adrs1]});
    end
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid0 && rvalid1) chk("rvalid_both", 1, 0);
      if (rvalid0 || rvalid1) begin
        if (sb.size() == 0) begin
          chk("rvalid_spurious", {rvalid1, rvalid0}, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("rv_port", {63'd0, rvalid1}, {63'd0, e.port});
          chk(rvalid1 ? "rdata1" : "rdata0", rvalid1 ? rdata1 : rdata0, e.data);
        end
      end
    end
  end

  initial begin
    logic [1:0] rr_seq [4];
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);

    @(negedge clk);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_ram_cs", ram_cs, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-port write then read, and hold after rvalid.
    drive(1, 1, 8'h00, 32'hcafecafe, 0, 0, 8'h00, 0); step(1, 0);
    drive(1, 0, 8'h00, 0, 0, 0, 8'h00, 0);            step(1, 0);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    chk("rvalid0_after_read", rvalid0, 1);
    chk("rdata0_after_read", rdata0, 32'hcafecafe);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(0, 0);
    @(negedge clk);
    chk("hold_rvalid0", rvalid0, 0);
    chk("hold_rdata0", rdata0, 32'hcafecafe);
    @(posedge clk); #1;

    // Preload via port 1 (also leaves port 1 as last winner).
    drive(0, 0, 8'h00, 0, 1, 1, 8'h01, 32'h33333333); step(0, 1);
    drive(0, 0, 8'h00, 0, 1, 1, 8'h02, 32'hcccccccc); step(0, 1);

    // Contention: both reading.
`ifdef SP1_RAM_ARB_RR_EN
    rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    rr_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
    for (int i = 0; i < 4; i++) step(rr_seq[i][0], rr_seq[i][1]);
    drive(0, 0, 8'h00, 0, 1, 0, 8'h02, 0); step(0, 1);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0); step(0, 0);

    // Write by port 1 then immediate read of the same address by port 0.
    drive(0, 0, 8'h00, 0, 1, 1, 8'hff, 32'hbeefbeef); step(0, 1);
    drive(1, 0, 8'hff, 0, 0, 0, 8'h00, 0);            step(1, 0);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    chk("hazard_rdata0", rdata0, 32'hbeefbeef);
    @(posedge clk); #1;
    step(0, 0);

    // Reset 2 ns after a read-grant edge drops the pending rvalid.
    drive(1, 0, 8'h00, 0, 0, 0, 8'h00, 0); step(1, 0);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rvalid0", rvalid0, 0);
    chk("midrst_rdata0", rdata0, 0);
    chk("midrst_rdata1", rdata1, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0);

    // X request on port 1 must not grant or leak X onto the RAM pins.
    req1 = 1'bx;
    @(negedge clk);
    chk("x_gnt1", gnt1, 0);
    chk("x_ram_cs", ram_cs, 0);
    chk("x_ram_pins_known", $isunknown({ram_cs, ram_we, ram_adrs, ram_din}), 0);
    @(posedge clk); #1;
    req1 = 1'b0;
    step(0, 0);
    step(0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
